// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for regfile_wb_arbiter: pipeline writeback, mul/div result path,
// issue/scoreboard query, and the register-file write port.
interface regfile_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  qa;
  logic [4:0]  qb;
  logic        qa_busy;
  logic        qb_busy;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] Di;

  modport master (
    output wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
           iss_valid, iss_rd, qa, qb,
    input  wb_stall, md_ready, qa_busy, qb_busy, RegWr, Rw, Di
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, md_valid, md_rd, md_data,
           iss_valid, iss_rd, qa, qb,
    output wb_stall, md_ready, qa_busy, qb_busy, RegWr, Rw, Di
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered mul/div results,
// plus a busy scoreboard. Define REGFILE_ARB_AGE_EN for anti-starvation of the FIFO head.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic                 CLK,
  input logic                 Resetn,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX == 0) begin : g_param_check
    $error("regfile_wb_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
  end

  logic [4:0]  fifo_rd   [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   busy, busy_next;

  logic        full, empty, push, pop, starve, fifo_win, any_sel;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef REGFILE_ARB_AGE_EN
  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);
  logic [AGE_W-1:0] age;

  // Saturates at STARVE_MAX so a long-stuck head keeps priority without wrapping.
  always_ff @(posedge CLK) begin
    if (!Resetn || empty || pop)
      age <= '0;
    else if (age < AGE_W'(STARVE_MAX))
      age <= age + 1'b1;
  end

  assign starve       = (age >= AGE_W'(STARVE_MAX)) && !empty;
  assign bus.wb_stall = Resetn && starve && bus.wb_valid;
`else
  assign starve       = 1'b0;
  assign bus.wb_stall = 1'b0;
`endif

  always_comb begin
    fifo_win = !empty && (!bus.wb_valid || starve);
    any_sel  = bus.wb_valid || !empty;
    sel_rd   = fifo_win ? fifo_rd[rptr]   : bus.wb_rd;
    sel_data = fifo_win ? fifo_data[rptr] : bus.wb_data;
    // r0 writes are consumed (head still pops) but never reach the register file.
    pop      = Resetn && fifo_win;
    bus.md_ready = Resetn && !full;
    push     = bus.md_valid && bus.md_ready;
    bus.RegWr = Resetn && any_sel && (sel_rd != 5'd0);
    bus.Rw    = (Resetn && any_sel) ? sel_rd   : '0;
    bus.Di    = (Resetn && any_sel) ? sel_data : '0;
    bus.qa_busy = Resetn && busy[bus.qa];
    bus.qb_busy = Resetn && busy[bus.qb];
  end

  always_comb begin
    busy_next = busy;
    if (pop)
      busy_next[fifo_rd[rptr]] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (bus.iss_valid && bus.iss_rd != 5'd0)
      busy_next[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_rd[wptr]   <= bus.md_rd;
      fifo_data[wptr] <= bus.md_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      busy <= busy_next;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default build and REGFILE_ARB_AGE_EN).
module tb_regfile_wb_arbiter;
  logic CLK;
  logic Resetn;
  int   n_checks;
  int   n_fail;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .CLK    (CLK),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.wb_valid  = 1'b0; bus.wb_rd  = '0; bus.wb_data = '0;
    bus.md_valid  = 1'b0; bus.md_rd  = '0; bus.md_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.qa = '0; bus.qb = '0;
  endtask

  // Advance past the next posedge; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();

    // Reset with a pipeline request present.
    Resetn = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h11;
    bus.qa = 5'd3;
    tick();
    settle();
    check("rst_regwr", bus.RegWr, 0);
    check("rst_mdready", bus.md_ready, 0);
    check("rst_qabusy", bus.qa_busy, 0);
    check("rst_rw", bus.Rw, 0);
    check("rst_di", bus.Di, 0);
    check("rst_stall", bus.wb_stall, 0);
    tick();

    Resetn = 1'b1;
    settle();
    check("wb_regwr", bus.RegWr, 1);
    check("wb_rw", bus.Rw, 3);
    check("wb_di", bus.Di, 32'h11);
    check("wb_mdready", bus.md_ready, 1);
    tick();

    // Drain path with scoreboard.
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.qa = 5'd5;
    settle();
    check("drain_busy_pre", bus.qa_busy, 0);
    tick();
    bus.iss_valid = 1'b0;
    bus.md_valid = 1'b1; bus.md_rd = 5'd5; bus.md_data = 32'hAB;
    settle();
    check("drain_busy_issued", bus.qa_busy, 1);
    check("drain_empty_regwr", bus.RegWr, 0);
    tick();
    bus.md_valid = 1'b0;
    settle();
    check("drain_pop_regwr", bus.RegWr, 1);
    check("drain_pop_rw", bus.Rw, 5);
    check("drain_pop_di", bus.Di, 32'hAB);
    check("drain_pop_busy", bus.qa_busy, 1);
    tick();
    check("drain_after_busy", bus.qa_busy, 0);
    check("drain_after_regwr", bus.RegWr, 0);

    // Pipeline priority, fill to full, reject push while full.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      bus.md_valid = 1'b1; bus.md_rd = 5'(10 + i); bus.md_data = 32'h100 + 32'(i);
      settle();
      check("prio_rw", bus.Rw, 9);
      check("prio_mdready", bus.md_ready, 1);
      tick();
    end
    bus.md_rd = 5'd14; bus.md_data = 32'hDEAD;
    settle();
    check("full_mdready", bus.md_ready, 0);
    check("full_rw", bus.Rw, 9);
    tick();
    bus.md_valid = 1'b0;
    bus.wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("full_drain_regwr", bus.RegWr, 1);
      check("full_drain_rw", bus.Rw, 32'(10 + i));
      check("full_drain_di", bus.Di, 32'h100 + 32'(i));
      check("full_drain_mdready", bus.md_ready, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    check("full_drained_regwr", bus.RegWr, 0);

    // Same-cycle set and clear on r7; set wins.
    idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.qb = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h77;
    tick();
    bus.md_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    settle();
    check("setclr_rw", bus.Rw, 7);
    check("setclr_regwr", bus.RegWr, 1);
    tick();
    bus.iss_valid = 1'b0;
    settle();
    check("setclr_busy", bus.qb_busy, 1);

    // r0 head is popped without a write; the next entry follows immediately.
    bus.md_valid = 1'b1; bus.md_rd = 5'd0; bus.md_data = 32'h55;
    tick();
    bus.md_rd = 5'd8; bus.md_data = 32'h88;
    settle();
    check("r0_regwr", bus.RegWr, 0);
    tick();
    bus.md_valid = 1'b0;
    settle();
    check("r0_next_regwr", bus.RegWr, 1);
    check("r0_next_rw", bus.Rw, 8);
    check("r0_next_di", bus.Di, 32'h88);
    tick();

    // Pointer wrap: 12 entries streamed with push and pop overlapping.
    for (int i = 0; i < 12; i++) begin
      bus.md_valid = 1'b1; bus.md_rd = 5'(20 + (i % 4)); bus.md_data = 32'(i);
      settle();
      if (i > 0) begin
        check("wrap_rw", bus.Rw, 32'(20 + ((i - 1) % 4)));
        check("wrap_di", bus.Di, 32'(i - 1));
      end
      tick();
    end
    bus.md_valid = 1'b0;
    settle();
    check("wrap_last_di", bus.Di, 11);
    tick();
    check("wrap_empty_regwr", bus.RegWr, 0);

    // Starvation: one queued entry against a continuously valid pipeline.
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h22;
    bus.md_valid = 1'b1; bus.md_rd = 5'd12; bus.md_data = 32'hC0;
    tick();
    bus.md_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      settle();
`ifdef REGFILE_ARB_AGE_EN
      check("age_rw", bus.Rw, (k == 9) ? 32'd12 : 32'd2);
      check("age_stall", bus.wb_stall, (k == 9) ? 32'd1 : 32'd0);
`else
      check("noage_rw", bus.Rw, 2);
      check("noage_stall", bus.wb_stall, 0);
`endif
      tick();
    end
    bus.wb_valid = 1'b0;
    settle();
`ifdef REGFILE_ARB_AGE_EN
    check("age_after_regwr", bus.RegWr, 0);
`else
    check("noage_drain_rw", bus.Rw, 12);
    check("noage_drain_di", bus.Di, 32'hC0);
`endif
    tick();

    // Mid-run reset clears the scoreboard (r7 still busy here).
    bus.qb = 5'd7;
    settle();
    check("pre_rst_busy", bus.qb_busy, 1);
    Resetn = 1'b0;
    settle();
    check("rst2_qbbusy", bus.qb_busy, 0);
    tick();
    Resetn = 1'b1;
    settle();
    check("rst2_cleared", bus.qb_busy, 0);
    check("rst2_regwr", bus.RegWr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Schedules the single register-file write port (RegWr/Rw/Di) between two sources: the in-order pipeline writeback stage and a multi-cycle mul/div unit.
- Mul/div results are buffered in a small FIFO and drained in cycles where the pipeline does not write.
- Keeps a 32-entry scoreboard of registers with outstanding mul/div writes, so hazard logic can stall readers of Ra/Rb.

Parameters:
- DEPTH, 4: mul/div result FIFO entries (power of 2, ≥2).
- STARVE_MAX, 8: cycles a FIFO head may wait before forcing priority (only with REGFILE_ARB_AGE_EN).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Resetn  in  1  synchronous active-low reset, sampled on posedge CLK.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- wb_stall  out  1  pipeline writeback must hold (only with macro, else constant 0).
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  FIFO can accept (= not full).
- md_rd  in  5  mul/div destination.
- md_data  in  32  mul/div result.
- iss_valid  in  1  a mul/div op is issued this cycle.
- iss_rd  in  5  its destination.
- qa  in  5  scoreboard query A.
- qb  in  5  scoreboard query B.
- qa_busy  out  1  qa has an outstanding mul/div write.
- qb_busy  out  1  qb has an outstanding mul/div write.
- RegWr  out  1  register-file write enable.
- Rw  out  5  register-file write address.
- Di  out  32  register-file write data.

Behaviour:
- Reset (Resetn=0 at posedge):
  - FIFO emptied, scoreboard cleared, age counter 0.
  - Combinationally while Resetn=0: RegWr=0, md_ready=0, qa_busy=qb_busy=0, wb_stall=0, Rw=0, Di=0.
- Write port is combinational from current inputs and FIFO head; the register file commits it at the next posedge, so latency is 0 cycles.
- Arbitration, default priority pipeline > FIFO:
  - wb_valid=1: Rw=wb_rd, Di=wb_data, RegWr=1; FIFO head held.
  - else if FIFO non-empty: Rw/Di from head, RegWr=1, head popped at posedge.
  - else RegWr=0.
- r0 suppression: any selected write with address 0 drives RegWr=0 but still counts as consumed (a FIFO head to r0 is popped).
- FIFO push:
  - Occurs when md_valid and md_ready.
  - md_ready = !full; a pop in the same cycle does not raise md_ready (no full-bypass).
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits.
  - md_valid while full: data is not captured; the source must hold.
- Scoreboard:
  - iss_valid sets busy[iss_rd] (r0 is never set).
  - A FIFO pop clears busy[Rw] of the popped entry.
  - Set and clear of the same register in the same cycle: set wins.
  - qa_busy = busy[qa], qb_busy = busy[qb], read combinationally.
  - Issue to an already-busy register is illegal; upstream hazard logic prevents it. No checking is required.
- Pipeline writes never touch the scoreboard.

Optional Feature:
- Macro REGFILE_ARB_AGE_EN.
- With the macro:
  - The age counter increments each cycle the FIFO is non-empty and the head is not popped; it resets to 0 on pop or when empty.
  - When age ≥ STARVE_MAX, the FIFO head wins over the pipeline for that cycle.
  - wb_stall is asserted in that cycle iff wb_valid=1; the pipeline must re-present the same write next cycle.
- Without the macro: strict pipeline priority, no age counter, wb_stall tied 0.

Test Plan:
- Reset: hold Resetn=0 for 2 cycles with wb_valid=1 → RegWr=0, md_ready=0, qa_busy=0. Release → wb_valid=1, wb_rd=3, wb_data=0x11 gives RegWr=1, Rw=3, Di=0x11.
- Drain path:
  - Issue rd=5, then md_valid with rd=5, data=0xAB while wb_valid=0.
  - Required: qa=5 reads busy=1 until the pop cycle; in that cycle RegWr=1, Rw=5, Di=0xAB; the next cycle shows busy=0.
- Priority and full:
  - wb_valid=1 continuously, push DEPTH(4) results → md_ready=0 after the 4th push.
  - Drop wb_valid → 4 consecutive writes in push order, md_ready=1 after the first pop.
- Same-cycle set and clear:
  - Head pops rd=7 while iss_valid with iss_rd=7 → busy[7] remains 1.
  - Separately, a head with rd=0 is popped with RegWr=0.
- Wrap: push/pop 3×DEPTH entries with data=index → every Di is in order, no loss or duplicate.
- AGE_EN, STARVE_MAX=8:
  - FIFO holds one entry, wb_valid=1 continuously.
  - Required: head is written in the 9th cycle with wb_stall=1 in that cycle only.
  - Without the macro: the head waits until wb_valid=0.
